// File: rtl/alu_operand_fetch_if.sv
// Handshake and write-back bundle between the issue logic, the operand-fetch stage and the ALU.
// The fetch stage takes the slave modport; whoever issues and consumes takes master.
interface alu_operand_fetch_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [3:0]  rd;
    logic        wb_en;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;

    modport master (
        output in_valid, instr, out_ready, wb_en, wb_rd, wb_data,
        input  in_ready, out_valid, op, src_a, src_b, rd
    );

    modport slave (
        input  in_valid, instr, out_ready, wb_en, wb_rd, wb_data,
        output in_ready, out_valid, op, src_a, src_b, rd
    );
endinterface

// File: rtl/alu_operand_fetch.sv
// Operand-fetch stage feeding the ALU: decodes one instruction, reads the register file
// with write-back bypass, and holds {op, src_a, src_b, rd} in a single pipeline slot.
module alu_operand_fetch #(
    parameter int NREGS = 16,
    parameter int IMM_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    alu_operand_fetch_if.slave bus
);
    localparam int IDX_W = $clog2(NREGS);

    logic [31:0]      rf_q [NREGS];
    logic             valid_q, valid_d;
    logic [2:0]       op_q, op_d;
    logic [31:0]      src_a_q, src_a_d;
    logic [31:0]      src_b_q, src_b_d;
    logic [IDX_W-1:0] rd_q, rd_d;

    logic [2:0]       dec_op;
    logic             dec_imm_sel;
    logic [IDX_W-1:0] dec_rd, dec_rs1, dec_rs2;
    logic [31:0]      dec_imm;
    logic [31:0]      rd1, rd2;
    logic             in_ready, accept;

    assign dec_op      = bus.instr[31:29];
    assign dec_imm_sel = bus.instr[28];
    assign dec_rd      = bus.instr[27:24];
    assign dec_rs1     = bus.instr[23:20];
    assign dec_rs2     = bus.instr[19:16];
    assign dec_imm     = {{(32-IMM_W){1'b0}}, bus.instr[IMM_W-1:0]};

    // Bypass lets an instruction see the value being written back in the same cycle.
    always_comb begin
        rd1 = '0;
        if (dec_rs1 != '0) begin
            rd1 = (bus.wb_en && bus.wb_rd == dec_rs1) ? bus.wb_data : rf_q[dec_rs1];
        end
    end

    always_comb begin
        rd2 = '0;
        if (dec_rs2 != '0) begin
            rd2 = (bus.wb_en && bus.wb_rd == dec_rs2) ? bus.wb_data : rf_q[dec_rs2];
        end
    end

    assign in_ready = !valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        op_d    = op_q;
        src_a_d = src_a_q;
        src_b_d = src_b_q;
        rd_d    = rd_q;
        if (accept) begin
            valid_d = 1'b1;
            op_d    = dec_op;
            src_a_d = rd1;
            src_b_d = dec_imm_sel ? dec_imm : rd2;
            rd_d    = dec_rd;
        end else if (valid_q && bus.out_ready) begin
            // Drain: data outputs keep their last values.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            op_q    <= '0;
            src_a_q <= '0;
            src_b_q <= '0;
            rd_q    <= '0;
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            op_q    <= op_d;
            src_a_q <= src_a_d;
            src_b_q <= src_b_d;
            rd_q    <= rd_d;
            if (bus.wb_en && bus.wb_rd != '0) begin
                rf_q[bus.wb_rd] <= bus.wb_data;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid_q;
    assign bus.op        = op_q;
    assign bus.src_a     = src_a_q;
    assign bus.src_b     = src_b_q;
    assign bus.rd        = rd_q;
endmodule

// File: tb/tb_alu_operand_fetch.sv
// Bench for alu_operand_fetch: directed scenarios plus random traffic, checked against an
// architectural register-file model and an in-order queue of expected ALU slots.
module tb_alu_operand_fetch;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    alu_operand_fetch_if bus ();

    alu_operand_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  rd;
    } slot_t;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_rf [16];
    slot_t       exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_instr(input logic [2:0] op, input logic imm_sel,
                                             input logic [3:0] rd, input logic [3:0] rs1,
                                             input logic [3:0] rs2, input logic [15:0] imm);
        return {op, imm_sel, rd, rs1, rs2, imm};
    endfunction

    // Architectural read: R0 is zero, a same-cycle write-back wins over the stored value.
    function automatic logic [31:0] arch_read(input logic [3:0] rs);
        if (rs == 4'd0) return 32'd0;
        if (bus.wb_en && bus.wb_rd == rs) return bus.wb_data;
        return model_rf[rs];
    endfunction

    task automatic drive(input logic iv, input logic [31:0] ins, input logic ordy,
                         input logic we, input logic [3:0] wr, input logic [31:0] wd);
        bus.in_valid  = iv;
        bus.instr     = ins;
        bus.out_ready = ordy;
        bus.wb_en     = we;
        bus.wb_rd     = wr;
        bus.wb_data   = wd;
    endtask

    task automatic clear_model();
        exp_q.delete();
        for (int i = 0; i < 16; i++) model_rf[i] = 32'd0;
    endtask

    // One clock: check outputs against the head of the expected queue, then advance the model.
    task automatic tick();
        slot_t e;
        logic  exp_rdy;
        #1;
        exp_rdy = (exp_q.size() == 0) || bus.out_ready;
        check("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
        check("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
            check("op", {29'd0, bus.op}, {29'd0, exp_q[0].op});
            check("src_a", bus.src_a, exp_q[0].a);
            check("src_b", bus.src_b, exp_q[0].b);
            check("rd", {28'd0, bus.rd}, {28'd0, exp_q[0].rd});
        end
        if (rst) begin
            clear_model();
        end else begin
            if (exp_q.size() != 0 && bus.out_ready) void'(exp_q.pop_front());
            if (bus.in_valid && exp_rdy) begin
                e.op = bus.instr[31:29];
                e.rd = bus.instr[27:24];
                e.a  = arch_read(bus.instr[23:20]);
                e.b  = bus.instr[28] ? {16'd0, bus.instr[15:0]} : arch_read(bus.instr[19:16]);
                exp_q.push_back(e);
            end
            if (bus.wb_en && bus.wb_rd != 4'd0) model_rf[bus.wb_rd] = bus.wb_data;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset with a stray instruction and write-back present, both of which must be dropped.
    task automatic do_reset();
        rst = 1'b1;
        drive(1'b1, mk_instr(3'd7, 1'b0, 4'd9, 4'd1, 4'd2, 16'h0), 1'b0, 1'b1, 4'd5, 32'hBAD0_BAD0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
        #1;
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_op", {29'd0, bus.op}, 32'd0);
        check("rst_src_a", bus.src_a, 32'd0);
        check("rst_src_b", bus.src_b, 32'd0);
        check("rst_rd", {28'd0, bus.rd}, 32'd0);
    endtask

    initial begin
        logic [31:0] ins;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
        clear_model();
        @(negedge clk);
        do_reset();

        // Register operands with a plain register-register instruction.
        drive(1'b0, 32'd0, 1'b0, 1'b1, 4'd3, 32'h5);  tick();
        drive(1'b0, 32'd0, 1'b0, 1'b1, 4'd4, 32'h7);  tick();
        drive(1'b1, mk_instr(3'b001, 1'b0, 4'd5, 4'd3, 4'd4, 16'h0), 1'b0, 1'b0, 4'd0, 32'd0);
        tick();
        check("t1_valid", {31'd0, bus.out_valid}, 32'd1);
        check("t1_op", {29'd0, bus.op}, 32'd1);
        check("t1_src_a", bus.src_a, 32'h5);
        check("t1_src_b", bus.src_b, 32'h7);
        check("t1_rd", {28'd0, bus.rd}, 32'd5);
        drive(1'b0, 32'd0, 1'b1, 1'b0, 4'd0, 32'd0);  tick();

        // Immediate operand is zero-extended.
        drive(1'b0, 32'd0, 1'b1, 1'b1, 4'd2, 32'hFFFF_0000);  tick();
        drive(1'b1, mk_instr(3'b110, 1'b1, 4'd1, 4'd2, 4'd9, 16'h1234), 1'b0, 1'b0, 4'd0, 32'd0);
        tick();
        check("t2_src_a", bus.src_a, 32'hFFFF_0000);
        check("t2_src_b", bus.src_b, 32'h0000_1234);
        drive(1'b0, 32'd0, 1'b1, 1'b0, 4'd0, 32'd0);  tick();

        // R0 ignores writes, including a same-cycle write.
        drive(1'b0, 32'd0, 1'b1, 1'b1, 4'd0, 32'hDEAD_BEEF);  tick();
        drive(1'b1, mk_instr(3'b010, 1'b0, 4'd7, 4'd0, 4'd0, 16'h0), 1'b0, 1'b1, 4'd0, 32'hDEAD_BEEF);
        tick();
        check("t3_src_a", bus.src_a, 32'd0);
        check("t3_src_b", bus.src_b, 32'd0);
        drive(1'b0, 32'd0, 1'b1, 1'b0, 4'd0, 32'd0);  tick();

        // Same-cycle bypass, then the stored value.
        drive(1'b1, mk_instr(3'b011, 1'b0, 4'd8, 4'd6, 4'd3, 16'h0), 1'b0, 1'b1, 4'd6, 32'hA5A5_A5A5);
        tick();
        check("t4_bypass", bus.src_a, 32'hA5A5_A5A5);
        drive(1'b1, mk_instr(3'b011, 1'b0, 4'd8, 4'd0, 4'd6, 16'h0), 1'b1, 1'b0, 4'd0, 32'd0);
        tick();
        check("t4_rf6", bus.src_b, 32'hA5A5_A5A5);
        drive(1'b0, 32'd0, 1'b1, 1'b0, 4'd0, 32'd0);  tick();

        // Backpressure for three cycles, then back-to-back flow.
        drive(1'b1, mk_instr(3'd1, 1'b1, 4'd1, 4'd3, 4'd0, 16'h0001), 1'b0, 1'b0, 4'd0, 32'd0);  tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, mk_instr(3'd2, 1'b1, 4'd2, 4'd4, 4'd0, 16'h0002), 1'b0, 1'b1, 4'd3, 32'h99 + i);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, mk_instr(i[2:0], 1'b0, 4'(i + 2), 4'd3, 4'd4, 16'h0), 1'b1, 1'b0, 4'd0, 32'd0);
            tick();
            check("t5_no_bubble", {31'd0, bus.out_valid}, 32'd1);
        end
        drive(1'b0, 32'd0, 1'b1, 1'b0, 4'd0, 32'd0);  tick();

        // Reset with a stalled slot; every register must read zero afterwards.
        drive(1'b1, mk_instr(3'd5, 1'b0, 4'd9, 4'd3, 4'd6, 16'h0), 1'b0, 1'b0, 4'd0, 32'd0);  tick();
        do_reset();
        for (int r = 1; r < 16; r += 2) begin
            drive(1'b1, mk_instr(3'd0, 1'b0, 4'd1, 4'(r), 4'(r + 1), 16'h0), 1'b1, 1'b0, 4'd0, 32'd0);
            tick();
        end
        drive(1'b0, 32'd0, 1'b1, 1'b0, 4'd0, 32'd0);  tick();

        // Random traffic; write-back often targets the incoming rs1 to exercise the bypass.
        for (int i = 0; i < 400; i++) begin
            ins = $urandom;
            drive($urandom_range(0, 3) != 0, ins, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 1) == 1) ? ins[23:20] : 4'($urandom_range(0, 15)),
                  $urandom);
            tick();
        end
        drive(1'b0, 32'd0, 1'b1, 1'b0, 4'd0, 32'd0);
        tick();
        tick();
        check("drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
